// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: one outstanding imem request per accepted PC,
// results buffered in a small FIFO for decode. Misaligned PCs bypass memory.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel,
  input  logic        id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   head_q, head_d;
  logic [AW-1:0]   tail_q, tail_d;
  logic            discard_q, discard_d;
  logic [31:0]     req_pc_q, req_pc_d;
  logic [31:0]     pc_mem_q [DEPTH];
  logic [31:0]     pc_mem_d [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     instr_mem_d [DEPTH];
  logic            adel_mem_q [DEPTH];
  logic            adel_mem_d [DEPTH];

  logic            accept;
  logic            misal;
  logic            resp;
  logic            push;
  logic            pop;
  logic [31:0]     push_pc;
  logic [31:0]     push_instr;
  logic            push_adel;

  assign pc_ready  = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !flush;
  assign accept    = pc_valid && pc_ready;
  assign misal     = (pc[1:0] != 2'b00);
  assign resp      = (state_q == WAIT) && imem_rvalid;
  assign imem_req  = (state_q == REQ);
  assign imem_addr = req_pc_q;
  assign if_valid  = (count_q != '0);
  assign if_pc     = pc_mem_q[head_q];
  assign if_instr  = instr_mem_q[head_q];
  assign if_adel   = adel_mem_q[head_q];
  assign pop       = if_valid && id_ready && !flush;

  always_comb begin
    push       = 1'b0;
    push_pc    = req_pc_q;
    push_instr = imem_rdata;
    push_adel  = 1'b0;
    // accept already excludes flush; a flushed response must never land
    if (accept && misal) begin
      push       = 1'b1;
      push_pc    = pc;
      push_instr = 32'h0;
      push_adel  = 1'b1;
    end else if (resp && !discard_q && !flush) begin
      push = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: begin
        if (accept && !misal) begin
          req_pc_d = pc;
          state_d  = REQ;
        end
      end
      REQ:     state_d = WAIT;
      WAIT:    if (imem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (resp) begin
      discard_d = 1'b0;
    end else if (flush && (state_q != IDLE)) begin
      discard_d = 1'b1;
    end
  end

  always_comb begin
    count_d     = count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    adel_mem_d  = adel_mem_q;
    if (push) begin
      pc_mem_d[tail_q]    = push_pc;
      instr_mem_d[tail_q] = push_instr;
      adel_mem_d[tail_q]  = push_adel;
    end
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_q + CW'(push) - CW'(pop);
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      discard_q <= 1'b0;
      req_pc_q  <= RESET_PC;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
        adel_mem_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      discard_q   <= discard_d;
      req_pc_q    <= req_pc_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
      adel_mem_q  <= adel_mem_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(DEPTH)) && !pop));
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a queue-based
// reference model with a variable-latency memory responder.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_adel;
  logic        id_ready;

  always #5 clk = ~clk;

  instr_fetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_adel     (if_adel),
    .id_ready    (id_ready)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  ent_t        mq[$];
  bit          m_issue;
  bit          m_wait;
  bit          m_disc;
  logic [31:0] m_req_pc;
  int          mem_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_resets = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_issue  = 1'b0;
    m_wait   = 1'b0;
    m_disc   = 1'b0;
    m_req_pc = 32'h0000_3000;
    mem_cnt  = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".pc_ready"},  {31'b0, pc_ready},  32'd1);
    chk({tag, ".imem_req"},  {31'b0, imem_req},  32'd0);
    chk({tag, ".imem_addr"}, imem_addr,          32'h0000_3000);
    chk({tag, ".if_valid"},  {31'b0, if_valid},  32'd0);
    chk({tag, ".if_pc"},     if_pc,              32'd0);
    chk({tag, ".if_instr"},  if_instr,           32'd0);
    chk({tag, ".if_adel"},   {31'b0, if_adel},   32'd0);
  endtask

  initial begin
    bit   exp_ready;
    bit   accept;
    bit   resp;
    bit   misal;
    int   p_idr;
    int   p_fl;
    ent_t e;

    reset       = 1'b1;
    pc          = '0;
    pc_valid    = 1'b0;
    flush       = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    id_ready    = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("por");

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = 1'b0;

      // asynchronous reset in the middle of a fetch with entries queued
      if ((n_resets == 0 && cyc > 800 && m_wait && mq.size() >= 2) ||
          (n_resets == 1 && cyc > 2000 && (m_wait || m_issue))) begin
        pc_valid    = 1'b0;
        flush       = 1'b0;
        id_ready    = 1'b0;
        imem_rvalid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        n_resets++;
        continue;
      end

      p_idr = (cyc < 1000) ? 25 : 70;
      p_fl  = (cyc < 1000) ? 2  : 10;
      id_ready = ($urandom_range(0, 99) < p_idr);
      flush    = ($urandom_range(0, 99) < p_fl);
      pc_valid = ($urandom_range(0, 99) < 70);
      misal    = ($urandom_range(0, 99) < 30);
      pc = 32'h0000_3000 + ($urandom_range(0, 63) << 2);
      if (misal) pc[1:0] = 2'($urandom_range(1, 3));
      imem_rdata = $urandom;
      if (m_wait) imem_rvalid = (mem_cnt == 1);
      else        imem_rvalid = ($urandom_range(0, 4) == 0);
      #1;

      exp_ready = !m_issue && !m_wait && (mq.size() < DEPTH) && !flush;
      chk("pc_ready",  {31'b0, pc_ready}, {31'b0, exp_ready});
      chk("imem_req",  {31'b0, imem_req}, {31'b0, m_issue});
      chk("imem_addr", imem_addr, m_req_pc);
      chk("if_valid",  {31'b0, if_valid}, {31'b0, mq.size() != 0});
      if (mq.size() != 0) begin
        chk("if_pc",    if_pc,    mq[0].pc);
        chk("if_instr", if_instr, mq[0].instr);
        chk("if_adel",  {31'b0, if_adel}, {31'b0, mq[0].adel});
      end

      accept = pc_valid && exp_ready;
      resp   = m_wait && imem_rvalid;
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() != 0 && id_ready) void'(mq.pop_front());
        if (accept && misal) begin
          e.pc = pc; e.instr = 32'h0; e.adel = 1'b1;
          mq.push_back(e);
        end
        if (resp && !m_disc) begin
          e.pc = m_req_pc; e.instr = imem_rdata; e.adel = 1'b0;
          mq.push_back(e);
        end
      end
      if (resp)                          m_disc = 1'b0;
      else if (flush && (m_issue || m_wait)) m_disc = 1'b1;
      if (m_wait && !resp) mem_cnt--;
      if (accept && !misal) begin
        m_req_pc = pc;
        m_issue  = 1'b1;
      end else if (m_issue) begin
        m_issue = 1'b0;
        m_wait  = 1'b1;
        mem_cnt = $urandom_range(1, 4);
      end else if (resp) begin
        m_wait = 1'b0;
      end
    end

    if (n_resets < 2) begin
      n_tests++;
      n_fail++;
      $display("FAIL async_rst_cov: got %0d resets expected 2", n_resets);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Instruction fetch stage sitting directly downstream of the PC register and upstream of decode. It accepts one PC per handshake, issues a single-outstanding request to a variable-latency instruction memory, and buffers returned {pc, instr, adel} entries in a DEPTH-entry FIFO for decode. It supports a flush from branch/jump redirect that empties the queue and discards any in-flight response. A PC that is not word-aligned is not fetched; it is queued immediately with an address-error flag.

## Interface
- DEPTH, 4: queue entries (power of two, ≥2)
- RESET_PC, 32'h00003000: reset value of the request-address register
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- pc  input  32  PC value offered by the PC register
- pc_valid  input  1  pc is valid this cycle
- pc_ready  output  1  block accepts pc this cycle (also the PC stall signal)
- flush  input  1  redirect; discard queue and in-flight fetch
- imem_req  output  1  memory request strobe, one cycle per request
- imem_addr  output  32  request word address
- imem_rvalid  input  1  response valid
- imem_rdata  input  32  response instruction
- if_valid  output  1  queue head valid
- if_pc  output  32  head PC
- if_instr  output  32  head instruction (0 when if_adel=1)
- if_adel  output  1  head PC was misaligned
- id_ready  input  1  decode consumes head

## Operation
- State machine: IDLE, REQ, WAIT.
- pc_ready = (state==IDLE) && (count<DEPTH) && !flush. Accept = pc_valid && pc_ready.
- IDLE, accept, pc[1:0]==0: req_pc<=pc; go REQ.
- IDLE, accept, pc[1:0]!=0: push {pc, 32'h0, adel=1} in the same cycle; stay IDLE; no memory request.
- REQ: imem_req=1, imem_addr=req_pc (both driven from registers; imem_addr holds req_pc at all times). Always go WAIT next cycle, even if flush.
- WAIT: on imem_rvalid, push {req_pc, imem_rdata, adel=0} unless discarded; go IDLE. imem_rvalid is ignored in IDLE and REQ.
- flush: count<=0 (head/tail pointers reset). In REQ or WAIT, set discard. In the cycle the response arrives, that response is not pushed, discard clears, and the state goes IDLE. flush in the same cycle as imem_rvalid drops that response. No accept occurs in a flush cycle.
- Queue: if_valid = (count!=0); head fields are combinational from the head entry. Pop = if_valid && id_ready && !flush. Simultaneous push and pop: count unchanged, both take effect.
- Overflow is impossible by construction. Accept requires count<DEPTH, only one entry is produced per accept, and pops only free space. An assertion must check that no push occurs with count==DEPTH && !pop.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Reset values: state=IDLE, count=0, discard=0, req_pc=RESET_PC. Outputs: pc_ready=1 (when !flush), imem_req=0, imem_addr=32'h00003000, if_valid=0, if_pc/if_instr/if_adel follow the cleared head entry (0).
- Reset mid-fetch: the outstanding response is dropped, because the state after reset is IDLE and rvalid is ignored.
- Aligned fetch: accept at cycle N; imem_req at N+1; earliest rvalid at N+2; entry visible on if_valid at N+3. Next pc_ready is at N+3. Peak throughput is one aligned instruction per 3 cycles with 1-cycle memory.
- Misaligned: accept at N; if_valid at N+1.
- Pop at cycle N: new head (or if_valid=0) visible at N+1.
- Flush at N: if_valid=0 at N+1. pc_ready returns at N+1 if IDLE; otherwise one cycle after the discarded response.

## Test plan
- Reset then pc=0x3000, pc_valid=1, memory latency 1 returning 0x24080001, id_ready=1 -> imem_req at cycle 1 with addr 0x3000; if_valid at cycle 3 with if_pc=0x3000, if_instr=0x24080001, if_adel=0.
- id_ready=0, issue 5 aligned PCs 0x3000..0x3010 -> 4 entries queued; pc_ready stays 0 once count=4; raise id_ready -> entries pop in order 0x3000..0x300c, then the fifth is fetched.
- pc=0x3002 -> no imem_req; if_valid next cycle with if_pc=0x3002, if_instr=0, if_adel=1.
- Request 0x3000, assert flush while in WAIT, memory returns 3 cycles later -> response not queued; if_valid stays 0; pc_ready returns the cycle after rvalid.
- Two entries queued, flush coincident with imem_rvalid and id_ready -> count=0 next cycle, nothing pushed or popped, state IDLE.
- Assert reset asynchronously mid-WAIT with 2 entries queued -> all outputs at reset values immediately; a late imem_rvalid is ignored.
